// File: rtl/hex_keypad_pkg.sv
// -----------------------------------------------------------------------------
// hex_keypad_pkg
// Shared definitions for the Grayhill 4x4 hex keypad scanner:
//   - state_e      : scanner states S_0 (idle), S_1..S_4 (scan column 0..3),
//                    S_5 (key held)
//   - COL_*        : column drive patterns (active-high, bit j = column j)
//   - NO_KEY_CODE  : default Code value when no single key is decoded
//   - col_drive()  : column pattern driven in a given state
//   - is_one_hot() : true when exactly one bit of a 4-bit vector is set
// -----------------------------------------------------------------------------
package hex_keypad_pkg;

  typedef enum logic [2:0] {
    S_0 = 3'd0,  // idle, all columns driven, waiting for S_Row
    S_1 = 3'd1,  // scanning column 0
    S_2 = 3'd2,  // scanning column 1
    S_3 = 3'd3,  // scanning column 2
    S_4 = 3'd4,  // scanning column 3
    S_5 = 3'd5   // key held, all columns driven until release
  } state_e;

  localparam logic [3:0] COL_ALL = 4'b1111;
  localparam logic [3:0] COL_0   = 4'b0001;
  localparam logic [3:0] COL_1   = 4'b0010;
  localparam logic [3:0] COL_2   = 4'b0100;
  localparam logic [3:0] COL_3   = 4'b1000;

  localparam logic [3:0] NO_KEY_CODE = 4'h0;

  // Column pattern for a state. Idle and held both drive every column so any
  // pressed key shows up on the rows.
  function automatic logic [3:0] col_drive(input state_e s);
    case (s)
      S_1:     col_drive = COL_0;
      S_2:     col_drive = COL_1;
      S_3:     col_drive = COL_2;
      S_4:     col_drive = COL_3;
      default: col_drive = COL_ALL;
    endcase
  endfunction

  function automatic logic is_one_hot(input logic [3:0] v);
    is_one_hot = (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/keypad_code_decoder.sv
// -----------------------------------------------------------------------------
// keypad_code_decoder
// Purely combinational Row/Col to hex-code decoder.
//   Code = 4*row_index + col_index when both Row and Col are one-hot,
//   otherwise NO_KEY_CODE (no key, several keys, or all columns driven).
// Ports:
//   row  [3:0] in  : keypad row lines, bit i = row i
//   col  [3:0] in  : column drive currently applied, bit j = column j
//   code [3:0] out : decoded hex code
// -----------------------------------------------------------------------------
module keypad_code_decoder
  import hex_keypad_pkg::*;
#(
  parameter logic [3:0] NO_KEY_CODE = hex_keypad_pkg::NO_KEY_CODE
) (
  input  logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] code
);

  logic [1:0] row_idx;
  logic [1:0] col_idx;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    row_idx = 2'd0;
    col_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row[i]) row_idx = 2'(i);
      if (col[i]) col_idx = 2'(i);
    end
  end

  always_comb begin
    code = NO_KEY_CODE;
    if (is_one_hot(row) && is_one_hot(col)) begin
      code = {row_idx, col_idx};
    end
  end

endmodule

// File: rtl/hex_keypad_grayhill_072.sv
// -----------------------------------------------------------------------------
// hex_keypad_grayhill_072
// Scanner for a Grayhill 4x4 hex keypad. Waits in S_0 for S_Row, then drives
// one column at a time (S_1..S_4). When a row answers, the key is reported on
// Code/Valid for that single scan cycle and the FSM parks in S_5 until every
// row goes low again.
//
// Ports:
//   clock       in      : sole clock, rising edge
//   reset       in      : synchronous active-low reset
//   S_Row       in      : synchronized "any row active" indication
//   Row   [3:0] in      : keypad rows, active-high
//   Col   [3:0] out     : column drive, active-high (registered)
//   Code  [3:0] out     : hex code of the detected key
//   Valid       out     : high while Code holds a detected key
//
// Configuration:
//   KEYPAD_REGISTERED_OUT_EN  when defined, Code and Valid are registered,
//                             appearing one cycle later and lasting one cycle.
//                             Col timing is the same in both builds.
// -----------------------------------------------------------------------------
module hex_keypad_grayhill_072
  import hex_keypad_pkg::*;
#(
  parameter logic [3:0] NO_KEY_CODE = hex_keypad_pkg::NO_KEY_CODE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       S_Row,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] Code,
  output logic       Valid
);

  state_e     state_q, state_d;
  logic [3:0] col_q,   col_d;

  logic       row_any;
  logic       scanning;
  logic       valid_comb;
  logic [3:0] code_comb;

  assign row_any  = (Row != 4'b0000);
  assign scanning = (state_q == S_1) || (state_q == S_2) ||
                    (state_q == S_3) || (state_q == S_4);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_0: state_d = S_Row ? S_1 : S_0;
      S_1: state_d = row_any ? S_5 : S_2;
      S_2: state_d = row_any ? S_5 : S_3;
      S_3: state_d = row_any ? S_5 : S_4;
      S_4: state_d = row_any ? S_5 : S_0;
      S_5: state_d = row_any ? S_5 : S_0;
      default: state_d = S_0;
    endcase
  end

  // Col is registered from the next state so it changes on the same edge as
  // the state and is glitch-free at the pins.
  assign col_d = col_drive(state_d);

  // ---------------------------------------------------------------------------
  // FSM state and column drive
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  // NOTE: reset is synchronous (sampled only on the clock edge), so there is
  // no asynchronous path into these flops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_0;
      col_q   <= COL_ALL;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
    end
  end

  assign Col = col_q;

  // ---------------------------------------------------------------------------
  // Key reporting
  // ---------------------------------------------------------------------------
  // A row answering during a scan state means a key was found in the column
  // being driven; that is the one cycle before S_5.
  assign valid_comb = scanning && row_any;

  keypad_code_decoder #(
    .NO_KEY_CODE (NO_KEY_CODE)
  ) u_decoder (
    .row  (Row),
    .col  (col_q),
    .code (code_comb)
  );

`ifdef KEYPAD_REGISTERED_OUT_EN
  logic       valid_q, valid_d;
  logic [3:0] code_q,  code_d;

  assign valid_d = valid_comb;
  assign code_d  = code_comb;

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q <= 1'b0;
      code_q  <= NO_KEY_CODE;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign Valid = valid_q;
  assign Code  = code_q;
`else
  assign Valid = valid_comb;
  assign Code  = code_comb;
`endif

endmodule

// File: tb/tb_hex_keypad_grayhill_072.sv
// -----------------------------------------------------------------------------
// tb_hex_keypad_grayhill_072
// Directed bench for the keypad scanner (default combinational-output build).
// A keypad model closes the loop: Row[i] = OR over j of (key[4i+j] & Col[j]).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_hex_keypad_grayhill_072;

  logic        clock;
  logic        reset;
  logic        S_Row;
  logic [3:0]  Row;
  logic [3:0]  Col;
  logic [3:0]  Code;
  logic        Valid;
  logic [15:0] key;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] NO_KEY = 4'h0;

  hex_keypad_grayhill_072 dut (
    .clock (clock),
    .reset (reset),
    .S_Row (S_Row),
    .Row   (Row),
    .Col   (Col),
    .Code  (Code),
    .Valid (Valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad model: a pressed key connects its column to its row.
  always_comb begin
    Row = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (key[4*i + j] && Col[j]) Row[i] = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Press key k, pulse S_Row, walk the scan and expect Valid exactly in the
  // column of the key, then S_5 while held and S_0 after release.
  task automatic press_key(input int k);
    int          col_hit;
    int          n_valid;
    logic [3:0]  exp_col;
    col_hit = k % 4;
    n_valid = 0;
    key   = 16'(1) << k;
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    for (int i = 0; i <= col_hit; i++) begin
      exp_col = 4'(1) << i;
      check($sformatf("key%0d_scan%0d_col", k, i), 32'(Col), 32'(exp_col));
      check($sformatf("key%0d_scan%0d_valid", k, i), 32'(Valid), 32'(i == col_hit));
      if (Valid) n_valid++;
      if (i == col_hit) check($sformatf("key%0d_code", k), 32'(Code), 32'(k));
      tick();
    end
    check($sformatf("key%0d_valid_count", k), 32'(n_valid), 32'd1);
    for (int h = 0; h < 2; h++) begin
      check($sformatf("key%0d_held%0d_col", k, h), 32'(Col), 32'hF);
      check($sformatf("key%0d_held%0d_valid", k, h), 32'(Valid), 32'd0);
      tick();
    end
    key = 16'h0000;
    tick();
    check($sformatf("key%0d_release_col", k), 32'(Col), 32'hF);
    check($sformatf("key%0d_release_valid", k), 32'(Valid), 32'd0);
    check($sformatf("key%0d_release_code", k), 32'(Code), 32'(NO_KEY));
    // Idle must ignore the rows once released: another cycle stays at 1111.
    tick();
    check($sformatf("key%0d_idle_col", k), 32'(Col), 32'hF);
  endtask

  initial begin
    reset = 1'b0;
    S_Row = 1'b0;
    key   = 16'h0000;

    // Reset held for two cycles.
    tick();
    tick();
    check("reset_col",   32'(Col),   32'hF);
    check("reset_valid", 32'(Valid), 32'd0);
    check("reset_code",  32'(Code),  32'(NO_KEY));
    reset = 1'b1;
    tick();
    check("idle_col", 32'(Col), 32'hF);

    // Key 0 walked by hand.
    key   = 16'h0001;
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    check("k0_s1_col",   32'(Col),   32'h1);
    check("k0_s1_valid", 32'(Valid), 32'd1);
    check("k0_s1_code",  32'(Code),  32'h0);
    tick();
    check("k0_s5_col",   32'(Col),   32'hF);
    check("k0_s5_valid", 32'(Valid), 32'd0);
    key = 16'h0000;
    tick();
    check("k0_s0_col", 32'(Col), 32'hF);

    // Key 5 walked by hand: nothing in column 0, hit in column 1.
    key   = 16'h0020;
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    check("k5_s1_col",   32'(Col),   32'h1);
    check("k5_s1_valid", 32'(Valid), 32'd0);
    tick();
    check("k5_s2_col",   32'(Col),   32'h2);
    check("k5_s2_valid", 32'(Valid), 32'd1);
    check("k5_s2_code",  32'(Code),  32'h5);
    tick();
    check("k5_s5_col", 32'(Col), 32'hF);
    key = 16'h0000;
    tick();
    check("k5_s0_col", 32'(Col), 32'hF);

    // Every key in turn.
    for (int k = 0; k < 16; k++) press_key(k);

    // Key 0xF: only in S_4.
    key   = 16'h8000;
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("kF_pre%0d_valid", i), 32'(Valid), 32'd0);
      tick();
    end
    check("kF_s4_col",   32'(Col),   32'h8);
    check("kF_s4_valid", 32'(Valid), 32'd1);
    check("kF_s4_code",  32'(Code),  32'hF);
    key = 16'h0000;
    tick();
    tick();
    check("kF_idle_col", 32'(Col), 32'hF);

    // Two rows in column 0: Valid high, Code falls back to NO_KEY.
    key   = 16'h0011;
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    check("multi_col",   32'(Col),   32'h1);
    check("multi_valid", 32'(Valid), 32'd1);
    check("multi_code",  32'(Code),  32'(NO_KEY));
    tick();
    check("multi_s5_col", 32'(Col), 32'hF);
    key = 16'h0000;
    tick();

    // S_Row pulse with no key: full scan, Valid never high, back to idle.
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("empty_s%0d_col", i + 1), 32'(Col), 32'(4'(1) << i));
      check($sformatf("empty_s%0d_valid", i + 1), 32'(Valid), 32'd0);
      tick();
    end
    check("empty_s0_col", 32'(Col), 32'hF);
    tick();
    check("empty_stay_col", 32'(Col), 32'hF);

    // Key released during the scan (key in column 3, lifted at S_2).
    key   = 16'h0008;
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    check("rel_s1_valid", 32'(Valid), 32'd0);
    tick();
    key = 16'h0000;
    check("rel_s2_col", 32'(Col), 32'h2);
    tick();
    tick();
    check("rel_s4_col",   32'(Col),   32'h8);
    check("rel_s4_valid", 32'(Valid), 32'd0);
    tick();
    check("rel_s0_col", 32'(Col), 32'hF);

    // Reset mid-scan.
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    tick();
    check("mid_s2_col", 32'(Col), 32'h2);
    reset = 1'b0;
    tick();
    check("mid_reset_col", 32'(Col), 32'hF);
    reset = 1'b1;
    tick();
    check("mid_after_col", 32'(Col), 32'hF);

    // Reset while held in S_5: with the key still down, S_0 without S_Row
    // must not start a scan.
    key   = 16'h0004;
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    tick();
    tick();
    check("s5_col", 32'(Col), 32'h4);
    tick();
    check("s5_held_col", 32'(Col), 32'hF);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("s5_reset_col",   32'(Col),   32'hF);
    check("s5_reset_valid", 32'(Valid), 32'd0);
    tick();
    check("s5_reset_idle_col", 32'(Col), 32'hF);
    S_Row = 1'b1;
    tick();
    S_Row = 1'b0;
    check("s5_rescan_col", 32'(Col), 32'h1);
    key = 16'h0000;
    tick();
    tick();
    tick();
    tick();
    check("final_idle_col", 32'(Col), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
